uart_rx_fifo_ctrl: RTL
======================

// Module: uart_rx_fifo_ctrl
// PURPOSE
//  Parametrised UART receive path: oversampled serial deframer, read-side RX FIFO and error reporting.
//  Sits between the RX pad synchroniser domain (already in clk) and the bus-side register block.
//  Generalises the RX control: configurable word width, FIFO depth, stop bits, optional parity check.
// PARAMETERS
//  DATA_W      8   data bits per frame, legal 5..9
//  OVERSAMPLE  16  baud_tick pulses per bit period, even, >=8
//  FIFO_DEPTH  16  RX FIFO entries, power of 2, >=2
//  STOP_BITS   1   stop bits checked, 1 or 2
// PORTS
//  clk              in   1                     system clock, all logic rising-edge
//  reset            in   1                     synchronous reset, active-high
//  baud_tick        in   1                     1-cycle strobe, OVERSAMPLE per bit period
//  rx               in   1                     serial input, idle high, LSB first
//  parity_odd       in   1                     1 = odd parity, 0 = even (used only with UART_RX_PARITY_EN)
//  read             in   1                     pop request from bus side
//  clear_err        in   1                     clears sticky error flags
//  rd_data          out  DATA_W                popped word, registered
//  rd_valid         out  1                     rd_data updated this cycle
//  empty            out  1                     FIFO empty
//  full             out  1                     FIFO full
//  count            out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  frame_err        out  1                     sticky: stop bit sampled 0
//  parity_err       out  1                     sticky: parity mismatch
//  overrun_err      out  1                     sticky: good word arrived while full
//  error_read_data  out  1                     1-cycle pulse: read while empty
// BEHAVIOUR
//  Reset (sync, one cycle): FSM=IDLE, rx sync regs=1, FIFO pointers/count=0, rd_data=0, rd_valid=0,
//   empty=1, full=0, all error flags 0. Reset mid-frame discards the partial word; FIFO contents lost.
//  rx passes a 2-FF synchroniser (reset to 1); FSM sees rx_s, 2 cycles latency.
//  Tick counter advances only on baud_tick; all bit timing is in ticks.
//  FSM: IDLE -> START on rx_s 1->0 edge (edge needs rx_s high the previous cycle; held-low break never retriggers).
//   START: wait OVERSAMPLE/2 ticks, sample; 0 -> DATA, 1 -> IDLE (glitch, no error).
//   DATA: sample every OVERSAMPLE ticks, shift in LSB first, DATA_W bits -> PARITY (macro) or STOP.
//   PARITY: sample one bit, compare -> STOP.
//   STOP: sample STOP_BITS bits at OVERSAMPLE spacing; any 0 -> frame_err, word dropped.
//   After last stop sample -> IDLE immediately (next start edge accepted within half a bit).
//  Word push: only frames with no frame/parity error; push occurs in the cycle of the final stop sample.
//  Push while full and no pop that cycle: word dropped, overrun_err set; FIFO unchanged.
//  Push and pop in same cycle: both succeed, count unchanged, also when full (pop frees slot first).
//  Pop: read && !empty -> rd_data = head, rd_valid = 1 next cycle (latency 1); else rd_valid=0, rd_data holds.
//  read && empty -> no pop, error_read_data = 1 for exactly the following cycle.
//  empty = (count==0), full = (count==FIFO_DEPTH), both registered-consistent with count.
//  Pointers are $clog2(FIFO_DEPTH) bits, wrap naturally modulo FIFO_DEPTH.
//  Sticky errors: clear_err clears; a new error event in the same cycle as clear_err wins (flag stays 1).
//  baud_tick during reset is ignored; tick counter restarts from 0 on every start-edge detection.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame carries one parity bit after data; mismatch vs parity_odd sets
//   parity_err and drops word.
//  Undefined: no PARITY state, frame = start+DATA_W+stop; parity_odd ignored, parity_err tied 0.
// TESTING
//  1 reset, then frame 0xA5 (8N1, OVERSAMPLE=16) -> count=1, empty=0; read -> rd_data=0xA5, rd_valid next cycle.
//  2 17 frames 0x00..0x10, no reads, FIFO_DEPTH=16 -> full=1, overrun_err=1, reads return 0x00..0x0F in order.
//  3 frame 0x3C with stop bit driven 0 -> frame_err=1, count=0; clear_err -> frame_err=0.
//  4 rx low for 4 ticks then high -> no word, no error, FSM back to IDLE; then 0x55 received correctly.
//  5 read with empty=1 -> error_read_data pulse 1 cycle, count stays 0; push+read same cycle when full -> count=16.
//  6 UART_RX_PARITY_EN, parity_odd=0, 0x07 with parity bit 0 -> parity_err=1, dropped; with bit 1 -> 0x07 stored.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive path: 2-FF rx synchroniser, tick-timed deframer FSM, RX FIFO and sticky error flags.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           baud_tick,
    input  logic                           rx,
    input  logic                           parity_odd,
    input  logic                           read,
    input  logic                           clear_err,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(FIFO_DEPTH):0]    count,
    output logic                           frame_err,
    output logic                           parity_err,
    output logic                           overrun_err,
    output logic                           error_read_data
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t              state, state_n;
    logic [TICK_W-1:0]   tick_cnt, tick_n, tick_last;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic                stop_bad, stop_bad_n, stop_bad_now;
    logic                par_bad;
    logic                rx_q1, rx_s, rx_s_d;
    logic                sample, frame_done;
    logic                push, push_ok, pop, frame_ev, parity_ev, overrun_ev;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count_n;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];

    // rx synchroniser plus one history stage for start-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q1  <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_q1  <= rx;
            rx_s   <= rx_q1;
            rx_s_d <= rx_s;
        end
    end

    // Start bit is sampled half a bit in, every later bit one full bit after the previous sample
    assign tick_last    = (state == S_START) ? TICK_W'(OVERSAMPLE / 2 - 1) : TICK_W'(OVERSAMPLE - 1);
    assign sample       = baud_tick && (tick_cnt == tick_last);
    assign stop_bad_now = stop_bad | ~rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            stop_bad <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            stop_bad <= stop_bad_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_n;

    always_ff @(posedge clk) begin
        if (reset) par_bad <= 1'b0;
        else       par_bad <= par_bad_n;
    end
`else
    logic parity_unused;

    assign par_bad       = 1'b0;
    assign parity_unused = parity_odd;
`endif

    always_comb begin
        state_n    = state;
        tick_n     = tick_cnt;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        stop_bad_n = stop_bad;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
`endif
        frame_done = 1'b0;
        if (baud_tick) tick_n = sample ? '0 : tick_cnt + 1'b1;
        case (state)
            S_IDLE: begin
                tick_n = '0;
                bit_n  = '0;
                if (rx_s_d && !rx_s) state_n = S_START;
            end
            S_START: begin
                if (sample) state_n = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample) begin
                    shreg_n = {rx_s, shreg[DATA_W-1:1]};
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        bit_n      = '0;
                        stop_bad_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_n    = S_PARITY;
`else
                        state_n    = S_STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample) begin
                    par_bad_n = ((^shreg) ^ rx_s) != parity_odd;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample) begin
                    stop_bad_n = stop_bad_now;
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Errors are reported once the frame completes; a pop in the same cycle frees a full slot
    assign frame_ev   = frame_done && stop_bad_now;
    assign parity_ev  = frame_done && par_bad;
    assign push       = frame_done && !stop_bad_now && !par_bad;
    assign pop        = read && !empty;
    assign push_ok    = push && (!full || pop);
    assign overrun_ev = push && full && !pop;

    always_comb begin
        count_n = count;
        if (push_ok && !pop)      count_n = count + 1'b1;
        else if (pop && !push_ok) count_n = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            empty           <= 1'b1;
            full            <= 1'b0;
            rd_data         <= '0;
            rd_valid        <= 1'b0;
            error_read_data <= 1'b0;
        end else begin
            count           <= count_n;
            empty           <= (count_n == '0);
            full            <= (count_n == CNT_W'(FIFO_DEPTH));
            rd_valid        <= pop;
            error_read_data <= read && empty;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    // Sticky flags: a new event outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (frame_ev)        frame_err   <= 1'b1;
            else if (clear_err)  frame_err   <= 1'b0;
            if (parity_ev)       parity_err  <= 1'b1;
            else if (clear_err)  parity_err  <= 1'b0;
            if (overrun_ev)      overrun_err <= 1'b1;
            else if (clear_err)  overrun_err <= 1'b0;
        end
    end

endmodule
